// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared state encodings and constants for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_DATA  = 2'd1;
    localparam state_t c_ST_FETCH = 2'd2;
    localparam state_t c_ST_STEP  = 2'd3;

    // addi x0, x0, 0 - handed to the CPU when a fetch is abandoned
    localparam logic [31:0] c_NOP_INSN = 32'h0000_0013;

    localparam int c_TIMEOUT_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout
// Description : Watchdog counting unacknowledged request cycles; flags expiry
//               on the TIMEOUT-th cycle that is still not acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT,
    parameter int TO_W    = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [TO_W-1:0] c_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_cnt_q;
    logic [TO_W-1:0] w_cnt_d;

    // Clear has priority so an ack in the final cycle is never an expiry
    assign o_expired = i_en & ~i_clr & (r_cnt_q == c_LAST);

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (i_clr || o_expired) begin
            w_cnt_d = '0;
        end else if (i_en) begin
            w_cnt_d = r_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises CPU data and instruction ports onto one single-port
//               bus, then pulses the CPU clock enable once per step.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT,
    parameter int TO_W    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_run,
    output logic        o_cpu_ce,
    input  logic [31:0] i_addr_i,
    output logic [31:0] o_data_i,
    input  logic [31:0] i_addr_d,
    input  logic [31:0] i_data_wr_d,
    input  logic [3:0]  i_wr_d,
    input  logic        i_rd_d,
    output logic [31:0] o_data_rd_d,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_we,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);

    state_t      r_state_q,   w_state_d;
    logic        r_req_q,     w_req_d;
    logic [31:0] r_addr_q,    w_addr_d;
    logic [31:0] r_wdata_q,   w_wdata_d;
    logic [3:0]  r_we_q,      w_we_d;
    logic [31:0] r_data_i_q,  w_data_i_d;
    logic [31:0] r_data_rd_q, w_data_rd_d;
    logic        r_err_q,     w_err_d;

    logic w_expired;
    logic w_done;

    bus_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_bus_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (~r_req_q | i_mem_ack),
        .i_en      (r_req_q),
        .o_expired (w_expired)
    );

    // The current access ends this cycle, either acked or abandoned
    assign w_done = r_req_q & (i_mem_ack | w_expired);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state_q   <= c_ST_IDLE;
            r_req_q     <= 1'b0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
            r_we_q      <= '0;
            r_data_i_q  <= c_NOP_INSN;
            r_data_rd_q <= '0;
            r_err_q     <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_req_q     <= w_req_d;
            r_addr_q    <= w_addr_d;
            r_wdata_q   <= w_wdata_d;
            r_we_q      <= w_we_d;
            r_data_i_q  <= w_data_i_d;
            r_data_rd_q <= w_data_rd_d;
            r_err_q     <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (i_run) begin
                    w_state_d = ((|i_wr_d) || i_rd_d) ? c_ST_DATA : c_ST_FETCH;
                end
            end
            c_ST_DATA: begin
                if (w_done) begin
                    w_state_d = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (w_done) begin
                    w_state_d = c_ST_STEP;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_req_d     = r_req_q;
        w_addr_d    = r_addr_q;
        w_wdata_d   = r_wdata_q;
        w_we_d      = r_we_q;
        w_data_i_d  = r_data_i_q;
        w_data_rd_d = r_data_rd_q;
        w_err_d     = r_err_q | w_expired;
        case (r_state_q)
            c_ST_DATA: begin
                if (!r_req_q) begin
                    w_req_d  = 1'b1;
                    w_addr_d = i_addr_d;
                    if (|i_wr_d) begin
                        w_we_d    = i_wr_d;
                        w_wdata_d = i_data_wr_d;
                    end else begin
                        w_we_d = '0;
                    end
                end else if (w_done) begin
                    if (r_we_q == 4'b0000) begin
                        w_data_rd_d = i_mem_ack ? i_mem_rdata : 32'h0;
                    end
                    // Fetch request follows immediately, keeping req high
                    w_req_d  = 1'b1;
                    w_addr_d = i_addr_i;
                    w_we_d   = '0;
                end
            end
            c_ST_FETCH: begin
                if (!r_req_q) begin
                    w_req_d  = 1'b1;
                    w_addr_d = i_addr_i;
                    w_we_d   = '0;
                end else if (w_done) begin
                    w_data_i_d = i_mem_ack ? i_mem_rdata : c_NOP_INSN;
                    w_req_d    = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_cpu_ce    = (r_state_q == c_ST_STEP);
    assign o_mem_req   = r_req_q;
    assign o_mem_addr  = r_addr_q;
    assign o_mem_wdata = r_wdata_q;
    assign o_mem_we    = r_we_q;
    assign o_data_i    = r_data_i_q;
    assign o_data_rd_d = r_data_rd_q;
    assign o_err       = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench: vector table of CPU steps, a reactive bus
//               model and a queue of expected bus requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_TIMEOUT = 4;
    localparam int c_NEVER   = 255;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_run;
    logic        o_cpu_ce;
    logic [31:0] i_addr_i;
    logic [31:0] o_data_i;
    logic [31:0] i_addr_d;
    logic [31:0] i_data_wr_d;
    logic [3:0]  i_wr_d;
    logic        i_rd_d;
    logic [31:0] o_data_rd_d;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_we;
    logic        o_mem_req;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_err;

    mem_arbiter #(.TIMEOUT(c_TIMEOUT), .TO_W(8)) u_dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_run       (i_run),
        .o_cpu_ce    (o_cpu_ce),
        .i_addr_i    (i_addr_i),
        .o_data_i    (o_data_i),
        .i_addr_d    (i_addr_d),
        .i_data_wr_d (i_data_wr_d),
        .i_wr_d      (i_wr_d),
        .i_rd_d      (i_rd_d),
        .o_data_rd_d (o_data_rd_d),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_we    (o_mem_we),
        .o_mem_req   (o_mem_req),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_err       (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  wr;
        logic        rd;
        logic [31:0] addr_d;
        logic [31:0] wdata;
        logic [31:0] addr_i;
        int          wait_d;
        int          wait_i;
        logic [31:0] rdata_d;
        logic [31:0] rdata_i;
        logic [31:0] exp_data_i;
        logic [31:0] exp_data_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] rdata;
    } req_t;

    req_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus model: serves requests in order, acking after the queued wait count
    logic mon_active = 1'b0;
    int   mon_wc     = 0;
    req_t mon_cur;

    always @(negedge i_clk) begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'hA5A5_A5A5;
        if (!i_rst_n) begin
            mon_active = 1'b0;
        end else if (o_mem_req) begin
            if (!mon_active) begin
                chk("req_expected", {31'b0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    mon_cur    = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_wc     = 0;
                    chk("req_addr", o_mem_addr, mon_cur.addr);
                    chk("req_we", {28'b0, o_mem_we}, {28'b0, mon_cur.we});
                    if (mon_cur.we != 4'b0000) chk("req_wdata", o_mem_wdata, mon_cur.wdata);
                end
            end else begin
                chk("req_addr_hold", o_mem_addr, mon_cur.addr);
                chk("req_we_hold", {28'b0, o_mem_we}, {28'b0, mon_cur.we});
                if (mon_cur.we != 4'b0000) chk("req_wdata_hold", o_mem_wdata, mon_cur.wdata);
            end
            if (mon_active) begin
                mon_wc++;
                if (mon_wc == mon_cur.wait_n + 1) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mon_cur.rdata;
                    mon_active  = 1'b0;
                end else if (mon_wc == c_TIMEOUT) begin
                    mon_active = 1'b0;
                end
            end
        end else if (mon_active) begin
            chk("req_held_until_done", {31'b0, o_mem_req}, 32'd1);
            mon_active = 1'b0;
        end
    end

    function automatic vec_t mk(input logic [3:0] wr, input logic rd,
                                input logic [31:0] addr_d, input logic [31:0] wdata,
                                input int wait_d, input logic [31:0] rdata_d,
                                input logic [31:0] addr_i, input int wait_i,
                                input logic [31:0] rdata_i, input logic [31:0] exp_data_i,
                                input logic [31:0] exp_data_rd, input logic exp_err,
                                input int exp_lat);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr_d = addr_d; v.wdata = wdata;
        v.wait_d = wait_d; v.rdata_d = rdata_d;
        v.addr_i = addr_i; v.wait_i = wait_i; v.rdata_i = rdata_i;
        v.exp_data_i = exp_data_i; v.exp_data_rd = exp_data_rd;
        v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Called mid-cycle while the DUT is in IDLE; returns mid-cycle after STEP
    task automatic do_step(input vec_t v, input string tag, input int drop_at);
        int   n;
        req_t r;
        if (v.wr != 4'b0000 || v.rd) begin
            r.addr = v.addr_d; r.we = v.wr; r.wdata = v.wdata;
            r.wait_n = v.wait_d; r.rdata = v.rdata_d;
            exp_q.push_back(r);
        end
        r.addr = v.addr_i; r.we = 4'b0000; r.wdata = 32'h0;
        r.wait_n = v.wait_i; r.rdata = v.rdata_i;
        exp_q.push_back(r);
        i_wr_d = v.wr; i_rd_d = v.rd; i_addr_d = v.addr_d;
        i_data_wr_d = v.wdata; i_addr_i = v.addr_i;
        i_run = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge i_clk);
            n++;
            if (n == drop_at) i_run = 1'b0;
            if (o_cpu_ce) break;
        end
        i_run = 1'b0;
        chk($sformatf("%s_latency", tag), n, v.exp_lat);
        chk($sformatf("%s_data_i", tag), o_data_i, v.exp_data_i);
        chk($sformatf("%s_data_rd", tag), o_data_rd_d, v.exp_data_rd);
        chk($sformatf("%s_err", tag), {31'b0, o_err}, {31'b0, v.exp_err});
        chk($sformatf("%s_all_served", tag), exp_q.size(), 32'd0);
        @(negedge i_clk);
        chk($sformatf("%s_ce_one_cycle", tag), {31'b0, o_cpu_ce}, 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk($sformatf("%s_req", tag), {31'b0, o_mem_req}, 32'd0);
        chk($sformatf("%s_we", tag), {28'b0, o_mem_we}, 32'd0);
        chk($sformatf("%s_ce", tag), {31'b0, o_cpu_ce}, 32'd0);
        chk($sformatf("%s_err", tag), {31'b0, o_err}, 32'd0);
        chk($sformatf("%s_addr", tag), o_mem_addr, 32'd0);
        chk($sformatf("%s_wdata", tag), o_mem_wdata, 32'd0);
        chk($sformatf("%s_data_rd", tag), o_data_rd_d, 32'd0);
        chk($sformatf("%s_data_i", tag), o_data_i, 32'h0000_0013);
    endtask

    vec_t vecs[9];

    initial begin
        int pulses;
        // wr, rd, addr_d, wdata, wait_d, rdata_d, addr_i, wait_i, rdata_i,
        // exp data_i, exp data_rd, exp err, exp latency
        vecs[0] = mk(4'b0000, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                     32'h100, 0, 32'h0050_0093, 32'h0050_0093, 32'h0, 1'b0, 3);
        vecs[1] = mk(4'b0011, 1'b0, 32'h2000, 32'h0000_BEEF, 2, 32'h0,
                     32'h104, 0, 32'h0000_0113, 32'h0000_0113, 32'h0, 1'b0, 6);
        vecs[2] = mk(4'b0000, 1'b1, 32'h2004, 32'h0, 0, 32'h1234_5678,
                     32'h108, 1, 32'h00A0_0193, 32'h00A0_0193, 32'h1234_5678, 1'b0, 5);
        vecs[3] = mk(4'b1111, 1'b1, 32'h2008, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF,
                     32'h10C, 0, 32'h0000_0213, 32'h0000_0213, 32'h1234_5678, 1'b0, 4);
        vecs[4] = mk(4'b0000, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                     32'h110, 3, 32'h0000_0313, 32'h0000_0313, 32'h1234_5678, 1'b0, 6);
        vecs[5] = mk(4'b0000, 1'b1, 32'h2010, 32'h0, 3, 32'h0BAD_F00D,
                     32'h114, 0, 32'h0000_0393, 32'h0000_0393, 32'h0BAD_F00D, 1'b0, 7);
        vecs[6] = mk(4'b0000, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                     32'h118, c_NEVER, 32'hFFFF_FFFF, 32'h0000_0013, 32'h0BAD_F00D, 1'b1, 6);
        vecs[7] = mk(4'b0000, 1'b1, 32'h2014, 32'h0, c_NEVER, 32'hFFFF_FFFF,
                     32'h11C, 0, 32'h0000_0413, 32'h0000_0413, 32'h0, 1'b1, 7);
        vecs[8] = mk(4'b0100, 1'b0, 32'h2018, 32'h1122_3344, c_NEVER, 32'h0,
                     32'h120, 1, 32'h0000_0513, 32'h0000_0513, 32'h0, 1'b1, 8);

        i_rst_n = 1'b0; i_run = 1'b0; i_addr_i = '0; i_addr_d = '0;
        i_data_wr_d = '0; i_wr_d = '0; i_rd_d = 1'b0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        repeat (3) @(negedge i_clk);
        chk_reset_values("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int k = 0; k < 9; k++) begin
            do_step(vecs[k], $sformatf("vec%0d", k), 0);
        end

        // Run drops one cycle into a load step: step completes, then freezes
        do_step(mk(4'b0000, 1'b1, 32'h2020, 32'h0, 0, 32'h55AA_55AA,
                   32'h124, 0, 32'h0000_0613, 32'h0000_0613, 32'h55AA_55AA, 1'b1, 4),
                "run_drop", 1);
        pulses = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_cpu_ce) pulses++;
        end
        chk("run_hold_no_ce", pulses, 32'd0);

        // Reset during a wait-stated fetch
        r_push_fetch(32'h128);
        i_addr_i = 32'h128; i_wr_d = '0; i_rd_d = 1'b0;
        i_run = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("pre_reset_req", {31'b0, o_mem_req}, 32'd1);
        i_rst_n = 1'b0;
        i_run   = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        chk_reset_values("midreset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("post_reset_idle_req", {31'b0, o_mem_req}, 32'd0);

        do_step(mk(4'b0000, 1'b0, 32'h0, 32'h0, 0, 32'h0,
                   32'h200, 0, 32'h0070_0393, 32'h0070_0393, 32'h0, 1'b0, 3),
                "after_reset", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic r_push_fetch(input logic [31:0] addr);
        req_t r;
        r.addr = addr; r.we = 4'b0000; r.wdata = 32'h0;
        r.wait_n = c_NEVER; r.rdata = 32'h0;
        exp_q.push_back(r);
    endtask

endmodule
`default_nettype wire
